// File: rtl/ex_ma_stage.sv
// EX->MA pipeline register with valid/ready handshake, cmp-written flags (E, GT)
// and a registered one-cycle branch redirect resolved against those flags.
module ex_ma_stage #(
  parameter int DW   = 32,
  parameter int RW   = 4,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_flush,
  input  logic [DW-1:0]   in_pc,
  input  logic [DW-1:0]   in_alu_result,
  input  logic [DW-1:0]   in_op2,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_is_cmp,
  input  logic            in_is_beq,
  input  logic            in_is_bgt,
  input  logic            in_is_ubr,
  input  logic [DW-1:0]   in_br_target,
  input  logic            in_is_ld,
  input  logic            in_is_st,
  input  logic            in_is_wb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_pc,
  output logic [DW-1:0]   out_alu_result,
  output logic [DW-1:0]   out_op2,
  output logic [RW-1:0]   out_rd,
  output logic            out_is_ld,
  output logic            out_is_st,
  output logic            out_is_wb,
  output logic            flag_e,
  output logic            flag_gt,
  output logic            br_taken,
  output logic [DW-1:0]   br_pc,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic {EMPTY, FULL} state_e;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] res;
    logic [DW-1:0] op2;
    logic [RW-1:0] rd;
    logic          ld;
    logic          st;
    logic          wb;
  } pay_t;

  state_e          state_q, state_d;
  pay_t            pay_q, pay_d;
  logic            flag_e_q, flag_e_d, flag_gt_q, flag_gt_d;
  logic            br_taken_q, br_taken_d;
  logic [DW-1:0]   br_pc_q, br_pc_d;
  logic [CNTW-1:0] stall_q, stall_d;
  logic            acc;

  assign in_ready = (state_q == EMPTY) || out_ready;
  assign acc      = in_valid && in_ready && !in_flush;

  always_comb begin
    state_d    = state_q;
    pay_d      = pay_q;
    flag_e_d   = flag_e_q;
    flag_gt_d  = flag_gt_q;
    br_taken_d = 1'b0;
    br_pc_d    = br_pc_q;
    stall_d    = stall_q;

    if (acc) begin
      state_d = FULL;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end

    if (acc) begin
      pay_d.pc  = in_pc;
      pay_d.res = in_alu_result;
      pay_d.op2 = in_op2;
      pay_d.rd  = in_rd;
      pay_d.ld  = in_is_ld;
      pay_d.st  = in_is_st;
      pay_d.wb  = in_is_wb && !in_is_cmp;
      // Branch sees the flags as registered before this edge; no cmp bypass.
      br_taken_d = in_is_ubr || (in_is_beq && flag_e_q) || (in_is_bgt && flag_gt_q);
      br_pc_d    = in_br_target;
      if (in_is_cmp) begin
        flag_e_d  = (in_alu_result == '0);
        flag_gt_d = (in_alu_result == DW'(1));
      end
    end

    if (state_q == FULL && !out_ready && stall_q != '1) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      pay_q      <= '0;
      flag_e_q   <= 1'b0;
      flag_gt_q  <= 1'b0;
      br_taken_q <= 1'b0;
      br_pc_q    <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      pay_q      <= pay_d;
      flag_e_q   <= flag_e_d;
      flag_gt_q  <= flag_gt_d;
      br_taken_q <= br_taken_d;
      br_pc_q    <= br_pc_d;
      stall_q    <= stall_d;
    end
  end

  assign out_valid      = (state_q == FULL);
  assign out_pc         = pay_q.pc;
  assign out_alu_result = pay_q.res;
  assign out_op2        = pay_q.op2;
  assign out_rd         = pay_q.rd;
  assign out_is_ld      = pay_q.ld;
  assign out_is_st      = pay_q.st;
  assign out_is_wb      = pay_q.wb;
  assign flag_e         = flag_e_q;
  assign flag_gt        = flag_gt_q;
  assign br_taken       = br_taken_q;
  assign br_pc          = br_pc_q;
  assign stall_cnt      = stall_q;

endmodule
